tracer_udma_stream_ctrl: RTL and testbench
==========================================

// Module: tracer_udma_stream_ctrl
// PURPOSE
//  Sequences trace packets from the trace encoder into the uDMA RX data channel.
//  - Buffers words in a commit/rewind FIFO.
//  - Releases a packet to the uDMA only after its last word has been accepted.
//  - Forwards words only while the RX channel is enabled.
//  - Drops whole packets on overflow, never partial ones, and counts the drops.
//  - Sits between the trace encoder and the uDMA RX port configured by the adapter register interface.
// PARAMETERS
//  DEPTH       16  FIFO depth in words; power of two, >=2
//  DATA_WIDTH  32  trace word width
//  CNT_WIDTH   16  width of the dropped-packet counter
// PORTS
//  clk_i               in   1             clock
//  rst_ni              in   1             asynchronous active-low reset
//  pkt_data_i          in   DATA_WIDTH    trace word from encoder
//  pkt_last_i          in   1             final word of packet
//  pkt_valid_i         in   1             encoder word valid
//  pkt_ready_o         out  1             block accepts word
//  data_rx_data_o      out  DATA_WIDTH    word to uDMA RX channel
//  data_rx_valid_o     out  1             word valid to uDMA
//  data_rx_ready_i     in   1             uDMA accepts word
//  data_rx_datasize_o  out  2             constant 2'b10 (word)
//  cfg_rx_en_i         in   1             RX channel running (from uDMA)
//  cfg_rx_clr_i        in   1             flush pulse (from reg if)
//  drop_clr_i          in   1             clear drop counter
//  drop_cnt_o          out  CNT_WIDTH     dropped packets, saturating
//  overflow_o          out  1             1-cycle pulse per dropped packet
//  fill_o              out  $clog2(DEPTH)+1  committed words in FIFO
// BEHAVIOUR
//  Reset: all pointers 0, state ACCEPT, in_pkt 0, drop_cnt_o 0, overflow_o 0,
//   data_rx_valid_o 0, pkt_ready_o 1, fill_o 0.
//  Pointers: rd, wr_spec, wr_commit are $clog2(DEPTH)+1 bits wide with natural wrap.
//   - full  = (wr_spec-rd)==DEPTH
//   - fill_o = wr_commit-rd
//   - full and fill_o come from registered pointers only; there is no same-cycle read bypass.
//  Input handshake is pkt_valid_i&pkt_ready_o. pkt_ready_o = (state!=FLUSH); the source is never stalled otherwise.
//  in_pkt is set on a non-last handshake and cleared on a last handshake.
//  FSM:
//   ACCEPT: on handshake, if !full write mem[wr_spec], wr_spec++.
//           If the word is last, wr_commit <= wr_spec+1.
//           If full: discard the word, wr_spec <= wr_commit, drop_cnt++, pulse overflow_o.
//           Stay in ACCEPT if the word was last, else go to DROP.
//   DROP:   discard every handshaked word; a last word returns to ACCEPT.
//   FLUSH:  one cycle with pkt_ready_o=0 and data_rx_valid_o=0.
//           Then go to DROP if in_pkt, else ACCEPT.
//  cfg_rx_clr_i (any state, highest priority):
//   - At that edge rd=wr_spec=wr_commit=0 and the next state is FLUSH.
//   - A word handshaked in the same cycle is discarded; in_pkt still updates.
//   - Flushed packets are not counted as drops.
//  A packet longer than DEPTH is always dropped (counted once).
//  Output:
//   - data_rx_valid_o = cfg_rx_en_i & (rd!=wr_commit) & (state!=FLUSH); data_rx_data_o = mem[rd].
//   - rd++ on data_rx_valid_o&data_rx_ready_i.
//   - Data is held stable while valid&!ready, unless cfg_rx_en_i drops or a flush occurs.
//  Latency: the last word accepted at edge N makes data_rx_valid_o high after edge N (earliest N+1 cycle).
//  Simultaneous read+write is allowed; a read frees space only from the next cycle.
//  drop_cnt_o saturates at all-ones. drop_clr_i wins over a same-cycle increment (result 0).
// STRUCTURE
//  tracer_pkg: typedef enum logic [1:0] {ACCEPT, DROP, FLUSH} stream_state_e; UDMA_DATASIZE_WORD=2'b10.
//  Sub-module tracer_pkt_fifo holds the commit/rewind FIFO:
//   - mem, rd/wr_spec/wr_commit, full, fill
//   - ports: push, commit, rewind, pop, flush
//  The top level holds the FSM, in_pkt, drop counter and uDMA gating.
// TESTING (DEPTH=4)
//  1. en=1, rx_ready=1, packet A0,A1,A2(last): valid rises the cycle after A2 is accepted.
//     A0,A1,A2 then appear on consecutive cycles; fill_o goes 3,2,1,0.
//  2. en=0, two 2-word packets give fill_o=4, valid=0.
//     A 1-word packet is then dropped: drop_cnt_o=1, overflow_o high 1 cycle.
//     Set en=1: 4 words drain in order.
//  3. Empty FIFO, 6-word packet: the 5th word overflows and rewinds, the 6th is discarded.
//     fill_o=0, drop_cnt_o=1; the next 2-word packet is delivered intact.
//  4. 2 words committed, 2 of a 3-word packet accepted, pulse cfg_rx_clr_i:
//     fill_o=0, one FLUSH cycle with ready=0, word 3 discarded in DROP, drop_cnt_o unchanged.
//     The next packet is delivered.
//  5. drop_cnt_o=16'hFFFE, two drops -> 16'hFFFF; then drop_clr_i with a simultaneous drop -> 0.
//  6. rx_ready pattern 1,0,1,0 on 3 committed words: data held stable on ready=0 cycles.
//     All 3 words delivered once each, in order.

Source files
------------

// File: rtl/tracer_pkg.sv
// Shared types and constants for the trace-to-uDMA streaming controller.
//   stream_state_e      : packet sequencing states of the top-level FSM
//   UDMA_DATASIZE_WORD  : uDMA datasize encoding for 32-bit transfers
package tracer_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    DROP   = 2'd1,
    FLUSH  = 2'd2
  } stream_state_e;

  localparam logic [1:0] UDMA_DATASIZE_WORD = 2'b10;

endpackage

// File: rtl/tracer_pkt_fifo.sv
// Commit/rewind FIFO for trace packets.
// Words are written speculatively at wr_spec; they become visible to the
// reader only once committed (wr_commit catches up). A rewind abandons the
// uncommitted tail of the current packet. Pointers carry one extra wrap bit.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push          : write push_data at wr_spec and advance it
//   push_data     : word to write
//   commit        : with push, publish everything up to and including this word
//   rewind        : return wr_spec to wr_commit (takes precedence over push)
//   pop           : advance rd
//   flush         : clear all pointers (highest priority)
//   rd_data       : word at rd
//   full          : speculative occupancy equals DEPTH
//   avail         : at least one committed word is readable
//   fill          : committed words not yet read
module tracer_pkt_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    commit,
  input  logic                    rewind,
  input  logic                    pop,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    avail,
  output logic [$clog2(DEPTH):0]  fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd;
  logic [PW-1:0]         wr_spec;
  logic [PW-1:0]         wr_commit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd        <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
    end else if (flush) begin
      rd        <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
    end else begin
      if (pop) rd <= rd + 1'b1;
      if (rewind) begin
        wr_spec <= wr_commit;
      end else if (push) begin
        wr_spec <= wr_spec + 1'b1;
        if (commit) wr_commit <= wr_spec + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_spec[AW-1:0]] <= push_data;
  end

  assign rd_data = mem[rd[AW-1:0]];
  assign full    = (wr_spec - rd) == DEPTH_P;
  assign avail   = rd != wr_commit;
  assign fill    = wr_commit - rd;

endmodule

// File: rtl/tracer_udma_stream_ctrl.sv
// Trace packet sequencer feeding the uDMA RX data channel.
// Packets are staged in a commit/rewind FIFO and only released once their
// last word is stored. A packet that does not fit is dropped whole (counted,
// with a one-cycle overflow pulse); cfg_rx_clr_i flushes everything without
// counting, and the remainder of an interrupted packet is then discarded.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   pkt_data_i/last/valid: encoder word stream; pkt_ready_o low only in FLUSH
//   data_rx_*            : uDMA RX stream; datasize fixed to word
//   cfg_rx_en_i          : uDMA RX channel enabled, gates output valid
//   cfg_rx_clr_i         : flush pulse
//   drop_clr_i           : clear the saturating drop counter
//   drop_cnt_o           : dropped packets
//   overflow_o           : one-cycle pulse per dropped packet
//   fill_o               : committed words buffered
module tracer_udma_stream_ctrl
  import tracer_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_WIDTH-1:0]   pkt_data_i,
  input  logic                    pkt_last_i,
  input  logic                    pkt_valid_i,
  output logic                    pkt_ready_o,
  output logic [DATA_WIDTH-1:0]   data_rx_data_o,
  output logic                    data_rx_valid_o,
  input  logic                    data_rx_ready_i,
  output logic [1:0]              data_rx_datasize_o,
  input  logic                    cfg_rx_en_i,
  input  logic                    cfg_rx_clr_i,
  input  logic                    drop_clr_i,
  output logic [CNT_WIDTH-1:0]    drop_cnt_o,
  output logic                    overflow_o,
  output logic [$clog2(DEPTH):0]  fill_o
);

  stream_state_e state_q, state_d;
  logic          in_pkt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;
  logic          overflow_q;

  logic hs;
  logic push, commit, rewind, drop, pop;
  logic full, avail;

  assign pkt_ready_o = (state_q != FLUSH);
  assign hs          = pkt_valid_i & pkt_ready_o;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    commit  = 1'b0;
    rewind  = 1'b0;
    drop    = 1'b0;
    // A flush overrides any write activity; the flushed data is not a drop.
    if (cfg_rx_clr_i) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        ACCEPT: begin
          if (hs) begin
            if (!full) begin
              push   = 1'b1;
              commit = pkt_last_i;
            end else begin
              // No room: abandon the whole packet, including words already stored.
              rewind = 1'b1;
              drop   = 1'b1;
              if (!pkt_last_i) state_d = DROP;
            end
          end
        end
        DROP: begin
          if (hs && pkt_last_i) state_d = ACCEPT;
        end
        FLUSH: begin
          state_d = in_pkt_q ? DROP : ACCEPT;
        end
        default: state_d = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ACCEPT;
      in_pkt_q   <= 1'b0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= drop;
      if (hs) in_pkt_q <= !pkt_last_i;
      if (drop_clr_i) begin
        drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign data_rx_valid_o    = cfg_rx_en_i & avail & (state_q != FLUSH);
  assign pop                = data_rx_valid_o & data_rx_ready_i;
  assign data_rx_datasize_o = UDMA_DATASIZE_WORD;
  assign drop_cnt_o         = drop_cnt_q;
  assign overflow_o         = overflow_q;

  tracer_pkt_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (push),
    .push_data (pkt_data_i),
    .commit    (commit),
    .rewind    (rewind),
    .pop       (pop),
    .flush     (cfg_rx_clr_i),
    .rd_data   (data_rx_data_o),
    .full      (full),
    .avail     (avail),
    .fill      (fill_o)
  );

endmodule

// File: tb/tb_tracer_udma_stream_ctrl.sv
module tb_tracer_udma_stream_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] pkt_data;
  logic          pkt_last, pkt_valid, pkt_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_ready;
  logic [1:0]    rx_datasize;
  logic          rx_en, rx_clr, drop_clr;
  logic [CW-1:0] drop_cnt;
  logic          overflow;
  logic [2:0]    fill;

  // Small instance for counter saturation: 2-bit counter, 2-word FIFO.
  logic          s_valid, s_last, s_ready, s_rx_valid, s_dclr;
  logic [DW-1:0] s_rx_data;
  logic [1:0]    s_datasize, s_drop, s_fill;
  logic          s_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  tracer_udma_stream_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .pkt_data_i(pkt_data), .pkt_last_i(pkt_last), .pkt_valid_i(pkt_valid), .pkt_ready_o(pkt_ready),
    .data_rx_data_o(rx_data), .data_rx_valid_o(rx_valid), .data_rx_ready_i(rx_ready),
    .data_rx_datasize_o(rx_datasize), .cfg_rx_en_i(rx_en), .cfg_rx_clr_i(rx_clr),
    .drop_clr_i(drop_clr), .drop_cnt_o(drop_cnt), .overflow_o(overflow), .fill_o(fill)
  );

  tracer_udma_stream_ctrl #(.DEPTH(2), .DATA_WIDTH(DW), .CNT_WIDTH(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .pkt_data_i(32'h5A5A_0000), .pkt_last_i(s_last), .pkt_valid_i(s_valid), .pkt_ready_o(s_ready),
    .data_rx_data_o(s_rx_data), .data_rx_valid_o(s_rx_valid), .data_rx_ready_i(1'b1),
    .data_rx_datasize_o(s_datasize), .cfg_rx_en_i(1'b0), .cfg_rx_clr_i(1'b0),
    .drop_clr_i(s_dclr), .drop_cnt_o(s_drop), .overflow_o(s_ovf), .fill_o(s_fill)
  );

  typedef struct {
    logic          v, l;
    logic [DW-1:0] d;
    logic          en, rdy, clr, dclr, sb;
    logic          e_rdy, e_val;
    logic [2:0]    e_fill;
    logic [CW-1:0] e_drop;
    logic          e_ovf;
  } vec_t;

  function automatic vec_t mk(input logic v, l, input logic [DW-1:0] d,
                              input logic en, rdy, clr, dclr, sb,
                              input logic e_rdy, e_val, input logic [2:0] e_fill,
                              input logic [CW-1:0] e_drop, input logic e_ovf);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.en = en; t.rdy = rdy; t.clr = clr; t.dclr = dclr; t.sb = sb;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_fill = e_fill; t.e_drop = e_drop; t.e_ovf = e_ovf;
    return t;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus after the edge, check outputs at the falling edge.
  // Words flagged sb are expected to reach the uDMA and go onto the scoreboard.
  task automatic apply(input string nm, input vec_t t);
    @(posedge clk); #1;
    pkt_valid = t.v; pkt_last = t.l; pkt_data = t.d;
    rx_en = t.en; rx_ready = t.rdy; rx_clr = t.clr; drop_clr = t.dclr;
    if (t.v && t.sb) exp_q.push_back(t.d);
    @(negedge clk);
    check({nm, ".ready"}, {31'd0, pkt_ready}, {31'd0, t.e_rdy});
    check({nm, ".valid"}, {31'd0, rx_valid},  {31'd0, t.e_val});
    check({nm, ".fill"},  {29'd0, fill},      {29'd0, t.e_fill});
    check({nm, ".drop"},  {16'd0, drop_cnt},  {16'd0, t.e_drop});
    check({nm, ".ovf"},   {31'd0, overflow},  {31'd0, t.e_ovf});
  endtask

  task automatic sat_step(input string nm, input logic v, l, dclr,
                          input logic [1:0] e_cnt, input logic e_ovf, input logic [1:0] e_fill);
    @(posedge clk); #1;
    s_valid = v; s_last = l; s_dclr = dclr;
    @(negedge clk);
    check({nm, ".cnt"},   {30'd0, s_drop},     {30'd0, e_cnt});
    check({nm, ".ovf"},   {31'd0, s_ovf},      {31'd0, e_ovf});
    check({nm, ".fill"},  {30'd0, s_fill},     {30'd0, e_fill});
    check({nm, ".valid"}, {31'd0, s_rx_valid}, 32'd0);
  endtask

  // Output scoreboard: while valid, data must match the oldest expected word
  // (covers hold-stable under backpressure); the word retires on ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
      end else begin
        check("rx_data", rx_data, exp_q[0]);
        if (rx_ready) void'(exp_q.pop_front());
      end
    end
  end

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    pkt_valid = 0; pkt_last = 0; pkt_data = '0;
    rx_en = 0; rx_ready = 0; rx_clr = 0; drop_clr = 0;
    s_valid = 0; s_last = 0; s_dclr = 0;

    // Test 1: 3-word packet with channel running.
    tbl.push_back(mk(1,0,32'hA0,1,1,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,0,32'hA1,1,1,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,1,32'hA2,1,1,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,3,0,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,2,0,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,0,0,0,0));
    // Test 2: fill with channel disabled, 1-word packet overflows, then drain.
    tbl.push_back(mk(1,0,32'hB0,0,1,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,1,32'hB1,0,1,0,0,1, 1,0,0,0,0));
    tbl.push_back(mk(1,0,32'hC0,0,1,0,0,1, 1,0,2,0,0));
    tbl.push_back(mk(1,1,32'hC1,0,1,0,0,1, 1,0,2,0,0));
    tbl.push_back(mk(1,1,32'hD0,0,1,0,0,0, 1,0,4,0,0));
    tbl.push_back(mk(0,0,32'h0 ,0,1,0,0,0, 1,0,4,1,1));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,4,1,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,3,1,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,2,1,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,1,1,1,0));
    tbl.push_back(mk(0,0,32'h0 ,1,1,0,0,0, 1,0,0,1,0));

    repeat (2) @(negedge clk);
    check("rst.ready",    {31'd0, pkt_ready}, 32'd1);
    check("rst.valid",    {31'd0, rx_valid},  32'd0);
    check("rst.fill",     {29'd0, fill},      32'd0);
    check("rst.drop",     {16'd0, drop_cnt},  32'd0);
    check("rst.ovf",      {31'd0, overflow},  32'd0);
    check("rst.datasize", {30'd0, rx_datasize}, 32'd2);
    check("rst.sat_cnt",  {30'd0, s_drop},    32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

    // Test 3: 6-word packet into empty FIFO; 5th word overflows, 6th discarded.
    for (int unsigned i = 0; i < 5; i++)
      apply($sformatf("long%0d", i), mk(1,0,32'hE0+i,1,1,0,0,0, 1,0,0,1,0));
    apply("long5", mk(1,1,32'hE5,1,1,0,0,0, 1,0,0,2,1));
    apply("f0",    mk(1,0,32'hF0,1,1,0,0,1, 1,0,0,2,0));
    apply("f1",    mk(1,1,32'hF1,1,1,0,0,1, 1,0,0,2,0));
    apply("f_d0",  mk(0,0,32'h0 ,1,1,0,0,0, 1,1,2,2,0));
    apply("f_d1",  mk(0,0,32'h0 ,1,1,0,0,0, 1,1,1,2,0));
    apply("f_d2",  mk(0,0,32'h0 ,1,1,0,0,0, 1,0,0,2,0));

    // Test 4: flush with a packet in progress; its last word is discarded.
    apply("g0",    mk(1,0,32'h60,0,1,0,0,0, 1,0,0,2,0));
    apply("g1",    mk(1,1,32'h61,0,1,0,0,0, 1,0,0,2,0));
    apply("h0",    mk(1,0,32'h70,0,1,0,0,0, 1,0,2,2,0));
    apply("h1",    mk(1,0,32'h71,0,1,0,0,0, 1,0,2,2,0));
    apply("clr",   mk(0,0,32'h0 ,0,1,1,0,0, 1,0,2,2,0));
    apply("flush", mk(1,0,32'h99,1,1,0,0,0, 0,0,0,2,0));
    apply("h2",    mk(1,1,32'h72,1,1,0,0,0, 1,0,0,2,0));
    apply("j0",    mk(1,0,32'h80,1,1,0,0,1, 1,0,0,2,0));
    apply("j1",    mk(1,1,32'h81,1,1,0,0,1, 1,0,0,2,0));
    apply("j_d0",  mk(0,0,32'h0 ,1,1,0,0,0, 1,1,2,2,0));
    apply("j_d1",  mk(0,0,32'h0 ,1,1,0,0,0, 1,1,1,2,0));
    apply("j_d2",  mk(0,0,32'h0 ,1,1,0,0,0, 1,0,0,2,0));

    // Test 6: backpressure 1,0,1,0,1 on 3 committed words.
    apply("k0",    mk(1,0,32'h90,0,1,0,0,1, 1,0,0,2,0));
    apply("k1",    mk(1,0,32'h91,0,1,0,0,1, 1,0,0,2,0));
    apply("k2",    mk(1,1,32'h92,0,1,0,0,1, 1,0,0,2,0));
    apply("bp0",   mk(0,0,32'h0 ,1,1,0,0,0, 1,1,3,2,0));
    apply("bp1",   mk(0,0,32'h0 ,1,0,0,0,0, 1,1,2,2,0));
    apply("bp2",   mk(0,0,32'h0 ,1,1,0,0,0, 1,1,2,2,0));
    apply("bp3",   mk(0,0,32'h0 ,1,0,0,0,0, 1,1,1,2,0));
    apply("bp4",   mk(0,0,32'h0 ,1,1,0,0,0, 1,1,1,2,0));
    apply("bp5",   mk(0,0,32'h0 ,1,1,0,0,0, 1,0,0,2,0));
    check("sb_empty", exp_q.size(), 32'd0);

    // Test 5: saturation and clear-wins on a 2-bit counter (2 = all-ones minus one).
    sat_step("s_p0", 1, 0, 0, 2'd0, 0, 2'd0);
    sat_step("s_p1", 1, 1, 0, 2'd0, 0, 2'd0);
    sat_step("s_q0", 1, 1, 0, 2'd0, 0, 2'd2);
    sat_step("s_q1", 1, 1, 0, 2'd1, 1, 2'd2);
    sat_step("s_q2", 1, 1, 0, 2'd2, 1, 2'd2);
    sat_step("s_q3", 1, 1, 0, 2'd3, 1, 2'd2);
    sat_step("s_clr",1, 1, 1, 2'd3, 1, 2'd2);
    sat_step("s_i0", 0, 0, 0, 2'd0, 1, 2'd2);
    sat_step("s_i1", 0, 0, 0, 2'd0, 0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
